deser_lanes: RTL and testbench
==============================

# deser_lanes

Parametrised multi-lane serial-to-parallel converter: the next generation of the single-bit deserializer. It accepts LANES bits per beat, packs them MSB-first or LSB-first into WIDTH-bit words, and presents each word on a valid/ready output. It sits between a serial receive front end and a word-oriented consumer that may apply backpressure. Optionally, it can flush a partially filled word.

## Interface
- WIDTH, 16: output word width in bits; must be a multiple of LANES.
- LANES, 1: bits accepted per input beat; 1..WIDTH.
- MSB_FIRST, 1: 1 = first beat lands in the MSBs; 0 = first beat lands in the LSBs.
- clk_i  in  1  clock.
- arst_i  in  1  reset; asynchronous, active-high.
- data_i  in  LANES  beat data; data_i[LANES-1] is the more significant bit of the beat.
- data_val_i  in  1  beat valid.
- data_ready_o  out  1  beat accepted on an edge where data_val_i && data_ready_o.
- data_last_i  in  1  final beat of a packet; present only with DESER_LAST_EN.
- deser_data_o  out  WIDTH  assembled word.
- deser_beats_o  out  $clog2(BEATS+1)  number of valid beats in deser_data_o.
- deser_data_val_o  out  1  word valid.
- deser_data_ready_i  in  1  consumer ready.

## Operation
- BEATS = WIDTH/LANES. Requires WIDTH % LANES == 0; otherwise elaboration fails with $error.
- The accumulator holds a beat counter (0..BEATS), a shift register, and an acc_full flag.
- MSB_FIRST=1: on each accepted beat, shift = {shift, data_i}.
- MSB_FIRST=0: on each accepted beat, write data_i at bit offset cnt*LANES.
- A word completes on the accepted beat that brings the count to BEATS. With DESER_LAST_EN, a word also completes on an accepted beat with data_last_i=1.
- The output stage has two states, EMPTY and FULL, tracked by deser_data_val_o.
  - Transfer is allowed when EMPTY, or when FULL && deser_data_ready_i on the same edge.
- On the completing edge, if transfer is allowed, the word loads directly into the output stage and the counter restarts at 0.
- On the completing edge, if transfer is not allowed, the word is held in the accumulator and acc_full is set.
- data_ready_o = !acc_full. It is derived from register state only; there is no combinational path from deser_data_ready_i.
- While acc_full is set, the word loads on the first edge where transfer is allowed. On that edge acc_full clears and the counter resets.
- Output handshake: deser_data_val_o stays high and deser_data_o/deser_beats_o stay stable until deser_data_ready_i is sampled high.
- Reset mid-word discards the partial word and any word held in the output stage.

## Timing
- Reset values: deser_data_o=0, deser_beats_o=0, deser_data_val_o=0, data_ready_o=1 (acc_full=0).
- Latency: completing beat accepted at edge N gives deser_data_val_o=1 after edge N when the output stage is free.
- Throughput is one beat per cycle with no bubbles between words, provided the consumer holds deser_data_ready_i=1.
- Backpressure: with the output FULL and not draining, the next completing beat sets acc_full. data_ready_o falls after that edge and rises after the edge that transfers the held word.
- Simultaneous drain and load on one edge: the new word replaces the old one and deser_data_val_o stays 1.
- data_val_i=0 cycles are idle: the counter and data hold.

## Configuration
- DESER_LAST_EN defined:
  - data_last_i exists.
  - A partial word completes with deser_beats_o = beats received.
  - Unfilled bits are zero. MSB_FIRST=1 places the received bits in the MSBs. MSB_FIRST=0 places them in the LSBs.
  - A last beat that is also beat BEATS completes a normal full word.
- DESER_LAST_EN undefined:
  - No data_last_i port.
  - Only full words are produced; deser_beats_o is constant BEATS.

## Structure
- Shared package deser_pkg:
  - beats-width helper function.
  - Output-stage state enum (OUT_EMPTY, OUT_FULL).
- Sub-module deser_out_stage: a one-entry valid/ready holding register, WIDTH plus the beats field wide. It exposes a load_allowed signal to the accumulator.
- The top level contains the accumulator, counter, acc_full logic and parameter checks.

## Test plan
- WIDTH=16, LANES=1, MSB_FIRST=1: send the 16 bits of 0xA5C3 MSB first with ready held high -> 0xA5C3 valid 1 cycle after the last bit, beats=16.
- WIDTH=16, LANES=4, MSB_FIRST=0: send beats 0x3, 0xC, 0x5, 0xA, then another four back-to-back -> first word 0xA5C3, second word on the 4th following cycle, no idle beats.
- Backpressure: hold deser_data_ready_i=0 and send 2 full words -> data_ready_o falls after the 2nd word completes. Raise ready -> both words emerge in order with none lost, and data_ready_o returns to 1.
- DESER_LAST_EN, WIDTH=16, LANES=4, MSB_FIRST=1: send 0xB, then 0x7 with last=1 -> deser_data_o=0xB700, beats=2; the next word starts from count 0.
- Assert arst_i asynchronously after 3 of 4 beats -> all outputs return to reset values immediately. A fresh 4-beat word after release is correct.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared types and helpers for the multi-lane deserializer.
package deser_pkg;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;
  function automatic int beats_w(input int beats);
    return $clog2(beats + 1);
  endfunction
endpackage

// File: rtl/deser_out_stage.sv
// deser_out_stage: one-entry valid/ready holding register for assembled words.
module deser_out_stage
  import deser_pkg::*;
#(
  parameter int W = 21
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         load_i,
  input  logic [W-1:0] word_i,
  input  logic         ready_i,
  output logic [W-1:0] word_o,
  output logic         val_o,
  output logic         load_allowed_o
);
  out_state_e st, st_nx;
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      st <= OUT_EMPTY;
      word_o <= '0;
    end else begin
      st <= st_nx;
      if (load_i) word_o <= word_i;
    end
  end
  always_comb begin
    st_nx = st;
    st_nx = load_i ? OUT_FULL : (ready_i ? OUT_EMPTY : st);
  end
  assign val_o = st == OUT_FULL;
  assign load_allowed_o = st == OUT_EMPTY || ready_i;
endmodule

// File: rtl/deser_lanes.sv
// deser_lanes: LANES-bit beats packed into WIDTH-bit words on a valid/ready output.
// DESER_LAST_EN adds data_last_i to flush partially filled words.
module deser_lanes
  import deser_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic [LANES-1:0]                    data_i,
  input  logic                                data_val_i,
  output logic                                data_ready_o,
`ifdef DESER_LAST_EN
  input  logic                                data_last_i,
`endif
  output logic [WIDTH-1:0]                    deser_data_o,
  output logic [beats_w(WIDTH/LANES)-1:0]     deser_beats_o,
  output logic                                deser_data_val_o,
  input  logic                                deser_data_ready_i
);
  localparam int BEATS = WIDTH / LANES;
  localparam int BW = beats_w(BEATS);
  if (WIDTH % LANES != 0 || LANES < 1 || LANES > WIDTH) begin : g_bad_cfg
    $error("deser_lanes: WIDTH must be a positive multiple of LANES");
  end
  logic [BW-1:0] cnt, cnt_nx, ld_beats;
  logic [WIDTH-1:0] shift, shift_nx, aligned, ld_word;
  logic acc_full, accept, last, done, load, load_allowed;
`ifdef DESER_LAST_EN
  assign last = data_last_i;
`else
  assign last = 1'b0;
`endif
  // A held word is stored already aligned so it can load straight from shift.
  always_comb begin
    accept = data_val_i && !acc_full;
    cnt_nx = cnt + 1'b1;
    shift_nx = MSB_FIRST ? WIDTH'({shift, data_i}) : shift | (WIDTH'(data_i) << (int'(cnt) * LANES));
    aligned = MSB_FIRST ? shift_nx << ((BEATS - int'(cnt_nx)) * LANES) : shift_nx;
    done = accept && (cnt_nx == BW'(BEATS) || last);
    load = (acc_full || done) && load_allowed;
    ld_word = acc_full ? shift : aligned;
    ld_beats = acc_full ? cnt : cnt_nx;
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt <= '0;
      shift <= '0;
      acc_full <= 1'b0;
    end else if (acc_full) begin
      if (load_allowed) begin
        acc_full <= 1'b0;
        cnt <= '0;
        shift <= '0;
      end
    end else if (done) begin
      if (load_allowed) begin
        cnt <= '0;
        shift <= '0;
      end else begin
        acc_full <= 1'b1;
        cnt <= cnt_nx;
        shift <= aligned;
      end
    end else if (accept) begin
      cnt <= cnt_nx;
      shift <= shift_nx;
    end
  end
  assign data_ready_o = !acc_full;
  deser_out_stage #(.W(WIDTH + BW)) u_out (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .load_i         (load),
    .word_i         ({ld_beats, ld_word}),
    .ready_i        (deser_data_ready_i),
    .word_o         ({deser_beats_o, deser_data_o}),
    .val_o          (deser_data_val_o),
    .load_allowed_o (load_allowed)
  );
endmodule

// File: tb/tb_deser_lanes.sv
// tb_deser_lanes: scoreboard bench for deser_lanes across several configurations.
module tb_deser_lanes;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst;
  logic [0:0] a_d;
  logic a_v, a_rdy, a_ov, a_ordy;
  logic [15:0] a_o;
  logic [4:0] a_beats;
  logic [3:0] b_d;
  logic b_v, b_rdy, b_ov, b_ordy;
  logic [15:0] b_o;
  logic [2:0] b_beats;
  logic [20:0] qa[$];
  logic [20:0] qb[$];
  logic [20:0] qc[$];
  int n_cmp = 0;
  int n_bad = 0;

  deser_lanes #(.WIDTH(16), .LANES(1), .MSB_FIRST(1)) u_a (
    .clk_i(clk), .arst_i(arst), .data_i(a_d), .data_val_i(a_v), .data_ready_o(a_rdy),
`ifdef DESER_LAST_EN
    .data_last_i(1'b0),
`endif
    .deser_data_o(a_o), .deser_beats_o(a_beats), .deser_data_val_o(a_ov), .deser_data_ready_i(a_ordy)
  );
  deser_lanes #(.WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_b (
    .clk_i(clk), .arst_i(arst), .data_i(b_d), .data_val_i(b_v), .data_ready_o(b_rdy),
`ifdef DESER_LAST_EN
    .data_last_i(1'b0),
`endif
    .deser_data_o(b_o), .deser_beats_o(b_beats), .deser_data_val_o(b_ov), .deser_data_ready_i(b_ordy)
  );
`ifdef DESER_LAST_EN
  logic [3:0] c_d;
  logic c_v, c_last, c_rdy, c_ov;
  logic [15:0] c_o;
  logic [2:0] c_beats;
  deser_lanes #(.WIDTH(16), .LANES(4), .MSB_FIRST(1)) u_c (
    .clk_i(clk), .arst_i(arst), .data_i(c_d), .data_val_i(c_v), .data_ready_o(c_rdy),
    .data_last_i(c_last),
    .deser_data_o(c_o), .deser_beats_o(c_beats), .deser_data_val_o(c_ov), .deser_data_ready_i(1'b1)
  );
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [3:0] d);
    b_d = d;
    b_v = 1'b1;
    cyc();
    b_v = 1'b0;
  endtask

  // Pops the expected word whenever a transfer is about to happen on the next edge.
  task automatic monitor;
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (a_ov && a_ordy) begin
        if (qa.size() == 0) chk("a_extra_word", 32'd1, 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_word", {a_beats, a_o}, e);
        end
      end
      if (b_ov && b_ordy) begin
        if (qb.size() == 0) chk("b_extra_word", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_word", {2'b0, b_beats, b_o}, e);
        end
      end
`ifdef DESER_LAST_EN
      if (c_ov) begin
        if (qc.size() == 0) chk("c_extra_word", 32'd1, 32'd0);
        else begin
          e = qc.pop_front();
          chk("c_word", {2'b0, c_beats, c_o}, e);
        end
      end
`endif
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0] s1 [8];
    logic [3:0] s2 [8];
    s1 = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4};
    s2 = '{4'hF, 4'hE, 4'hD, 4'hC, 4'h0, 4'h8, 4'h0, 4'h8};
    arst = 1'b1;
    a_d = '0; a_v = 1'b0; a_ordy = 1'b1;
    b_d = '0; b_v = 1'b0; b_ordy = 1'b1;
`ifdef DESER_LAST_EN
    c_d = '0; c_v = 1'b0; c_last = 1'b0;
`endif
    fork
      monitor();
    join_none
    #12 arst = 1'b0;
    chk("rst_a_data", a_o, 0);
    chk("rst_a_beats", a_beats, 0);
    chk("rst_a_val", a_ov, 0);
    chk("rst_a_rdy", a_rdy, 1);
    chk("rst_b_val", b_ov, 0);
    chk("rst_b_rdy", b_rdy, 1);
    cyc();
    // 1-lane MSB-first word
    w = 16'hA5C3;
    qa.push_back({5'd16, 16'hA5C3});
    for (int i = 15; i >= 1; i--) begin
      a_d[0] = w[i];
      a_v = 1'b1;
      cyc();
    end
    chk("a_early_val", a_ov, 0);
    a_d[0] = w[0];
    cyc();
    a_v = 1'b0;
    chk("a_latency", a_ov, 1);
    cyc();
    chk("a_drained", a_ov, 0);
    // 4-lane LSB-first, two words back-to-back
    qb.push_back({5'd4, 16'hA5C3});
    qb.push_back({5'd4, 16'h4321});
    for (int i = 0; i < 8; i++) begin
      chk("b_rdy_stream", b_rdy, 1);
      send_b(s1[i]);
      chk("b_val_stream", b_ov, (i == 3 || i == 7) ? 1 : 0);
    end
    cyc();
    // backpressure: two words while the consumer stalls
    b_ordy = 1'b0;
    qb.push_back({5'd4, 16'hCDEF});
    qb.push_back({5'd4, 16'h8080});
    for (int i = 0; i < 8; i++) begin
      chk("b_rdy_bp", b_rdy, 1);
      send_b(s2[i]);
    end
    chk("b_rdy_held", b_rdy, 0);
    cyc();
    cyc();
    chk("b_rdy_stall", b_rdy, 0);
    chk("b_data_stable", b_o, 16'hCDEF);
    chk("b_val_stall", b_ov, 1);
    b_ordy = 1'b1;
    cyc();
    chk("b_rdy_release", b_rdy, 1);
    chk("b_val_reload", b_ov, 1);
    cyc();
    cyc();
    // async reset after 3 of 4 beats
    send_b(4'h9);
    send_b(4'h6);
    send_b(4'h1);
    #2 arst = 1'b1;
    #1;
    chk("arst_b_val", b_ov, 0);
    chk("arst_b_data", b_o, 0);
    chk("arst_b_beats", b_beats, 0);
    chk("arst_b_rdy", b_rdy, 1);
    @(posedge clk);
    #1 arst = 1'b0;
    cyc();
    qb.push_back({5'd4, 16'h7169});
    send_b(4'h9);
    send_b(4'h6);
    send_b(4'h1);
    send_b(4'h7);
    chk("b_fresh_val", b_ov, 1);
    cyc();
`ifdef DESER_LAST_EN
    qc.push_back({5'd2, 16'hB700});
    qc.push_back({5'd4, 16'h1234});
    c_v = 1'b1;
    c_d = 4'hB;
    cyc();
    c_d = 4'h7;
    c_last = 1'b1;
    cyc();
    c_last = 1'b0;
    chk("c_partial_val", c_ov, 1);
    for (int i = 1; i <= 4; i++) begin
      c_d = 4'(i);
      cyc();
    end
    c_v = 1'b0;
    chk("c_full_val", c_ov, 1);
`endif
    repeat (3) cyc();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
